// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin arbiter that lets N_REQ requesters share one
// external unsigned 20x8 multiplier of fixed latency MUL_LAT. Each accepted
// operation carries a {valid, id} tag down a shift pipeline that is aligned
// with the multiplier, so the tag and the product leave together and the
// result strobe goes back to the requester that owns it.
module mult_share_arb #(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hold,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*20-1:0]  req_a,
    input  logic [N_REQ*8-1:0]   req_y,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     res_valid,
    output logic [27:0]          res_p,
    output logic [19:0]          mul_a,
    output logic [7:0]           mul_y,
    output logic                 mul_ce,
    output logic                 mul_rst,
    input  logic [27:0]          mul_p,
    output logic                 busy,
    output logic [CNT_W-1:0]     issue_cnt
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef struct packed {
        logic             vld;
        logic [PTR_W-1:0] id;
    } tag_t;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [19:0]      mul_a_q, mul_a_d;
    logic [7:0]       mul_y_q, mul_y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mul_rst_q, mul_rst_d;
    tag_t             iss_q, iss_d;
    tag_t             tag_q [MUL_LAT];
    tag_t             tag_d [MUL_LAT];

    logic             found;
    logic [PTR_W-1:0] gnt_id;
    logic [PTR_W:0]   rr_idx;

    // Round-robin search starting at ptr_q; the first valid requester wins.
    always_comb begin
        req_ready = '0;
        gnt_id    = '0;
        found     = 1'b0;
        rr_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rr_idx = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (rr_idx >= (PTR_W+1)'(N_REQ)) begin
                rr_idx = rr_idx - (PTR_W+1)'(N_REQ);
            end
            if (!found && rst_n && !hold && req_valid[rr_idx[PTR_W-1:0]]) begin
                found                         = 1'b1;
                req_ready[rr_idx[PTR_W-1:0]]  = 1'b1;
                gnt_id                        = rr_idx[PTR_W-1:0];
            end
        end
    end

    // Issue stage: capture the winner's operands, advance pointer and counter.
    always_comb begin
        ptr_d     = ptr_q;
        mul_a_d   = mul_a_q;
        mul_y_d   = mul_y_q;
        cnt_d     = cnt_q;
        iss_d.vld = found;
        iss_d.id  = gnt_id;
        mul_rst_d = ~rst_n;
        if (found) begin
            ptr_d = (gnt_id == PTR_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
            cnt_d = cnt_q + 1'b1;
            for (int i = 0; i < N_REQ; i++) begin
                if (req_ready[i]) begin
                    mul_a_d = req_a[i*20 +: 20];
                    mul_y_d = req_y[i*8 +: 8];
                end
            end
        end
    end

    // Tag pipeline shifts every cycle, tracking the multiplier's own stages.
    always_comb begin
        tag_d[0] = iss_q;
        for (int s = 1; s < MUL_LAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end
    end

    // State registers; synchronous reset discards anything in flight.
    always_ff @(posedge clk) begin
        mul_rst_q <= mul_rst_d;
        if (!rst_n) begin
            ptr_q   <= '0;
            mul_a_q <= '0;
            mul_y_q <= '0;
            cnt_q   <= '0;
            iss_q   <= '0;
            for (int s = 0; s < MUL_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            ptr_q   <= ptr_d;
            mul_a_q <= mul_a_d;
            mul_y_q <= mul_y_d;
            cnt_q   <= cnt_d;
            iss_q   <= iss_d;
            for (int s = 0; s < MUL_LAT; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    // Result strobe to the tag owner; product passes straight through.
    always_comb begin
        res_valid = '0;
        if (rst_n && tag_q[MUL_LAT-1].vld) begin
            res_valid[tag_q[MUL_LAT-1].id] = 1'b1;
        end
    end

    // Busy while the issue stage or any tag stage holds an operation.
    always_comb begin
        busy = iss_q.vld;
        for (int s = 0; s < MUL_LAT; s++) begin
            busy = busy | tag_q[s].vld;
        end
    end

    assign res_p     = mul_p;
    assign mul_a     = mul_a_q;
    assign mul_y     = mul_y_q;
    assign mul_ce    = rst_n;
    assign mul_rst   = mul_rst_q;
    assign issue_cnt = cnt_q;

endmodule
